// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit ripple slice,
// one nibble per clock (LSB first), with valid/ready on both sides.

// fulladder_parameter: W-bit combinational adder slice with carry in/out.
module fulladder_parameter #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);
    logic [W:0] w_full;

    // Widen by one bit so the carry-out falls out of the addition.
    assign w_full = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
    assign s_o    = w_full[W-1:0];
    assign c_o    = w_full[W];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $fatal(1, "nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_d;
    logic [CW-1:0]         r_cnt;
    logic [N-1:0][3:0]     r_a_q;
    logic [N-1:0][3:0]     r_b_q;
    logic                  r_c_q;
    logic [N-1:0][3:0]     r_sum_q;
    logic [N-1:0][3:0]     w_sum_next;
    logic [3:0]            w_slice_s;
    logic                  w_slice_c;
    logic [WIDTH-1:0]      r_sum_o;
    logic                  r_carry_o;

    // The single shared slice: current nibble of each operand plus the running carry.
    fulladder_parameter #(.W(4)) u_slice (
        .a_i (r_a_q[r_cnt]),
        .b_i (r_b_q[r_cnt]),
        .c_i (r_c_q),
        .s_o (w_slice_s),
        .c_o (w_slice_c)
    );

    // Partial sum with the current nibble merged in; also feeds the output on the last step.
    always_comb begin
        w_sum_next        = r_sum_q;
        w_sum_next[r_cnt] = w_slice_s;
    end

    // Next-state decode; ready/valid are pure functions of state.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE:  if (valid_i)        w_state_d = S_CALC;
            S_CALC:  if (r_cnt == LAST)  w_state_d = S_DONE;
            S_DONE:  if (ready_i)        w_state_d = S_IDLE;
            default:                     w_state_d = S_IDLE;
        endcase
    end

    // State register; reset wins over any pending handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_d;
    end

    // Operand capture, per-nibble accumulation and result publication.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_c_q     <= 1'b0;
            r_sum_q   <= '0;
            r_sum_o   <= '0;
            r_carry_o <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_a_q   <= a_i;
                        r_b_q   <= b_i;
                        r_c_q   <= carry_i;
                        r_cnt   <= '0;
                        r_sum_q <= '0;
                    end
                end
                S_CALC: begin
                    r_sum_q <= w_sum_next;
                    r_c_q   <= w_slice_c;
                    if (r_cnt == LAST) begin
                        // Output regs only move here, so the previous result
                        // stays visible until this one is complete.
                        r_sum_o   <= w_sum_next;
                        r_carry_o <= w_slice_c;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o = (r_state == S_IDLE) && rst_ni;
    assign valid_o = (r_state == S_DONE);
    assign sum_o   = r_sum_o;
    assign carry_o = r_carry_o;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=32) against a plain
// arithmetic {carry,sum} reference.
module tb_nibble_serial_adder;
    localparam int W = 32;
    localparam int N = W / 4;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         carry_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] sum_o;
    logic         carry_o;

    int n_checks = 0;
    int n_errors = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .carry_i (carry_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sum_o   (sum_o),
        .carry_o (carry_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Handshake one operation in IDLE, then wait (bounded) for valid_o.
    // lat = edges after the accepting edge until valid_o seen; scramble
    // drives garbage operands while the block is busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit scramble, output int lat, output bit timeout);
        @(negedge clk_i);
        a_i = a; b_i = b; carry_i = c; valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        lat = 0;
        timeout = 1'b0;
        while (!valid_o) begin
            if (scramble) begin
                a_i = 32'hDEAD_BEEF; b_i = 32'hDEAD_BEEF; carry_i = 1'b1; valid_i = 1'b1;
            end
            if (lat > 40) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk_i);
            @(negedge clk_i);
            lat++;
        end
        valid_i = 1'b0;
    endtask

    task automatic consume();
        ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; valid_i = 1'b1; a_i = 5; b_i = 7; carry_i = 1'b0; ready_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i);
            @(negedge clk_i);
            n_checks++;
            if ({valid_o, ready_o, sum_o, carry_o} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
                n_errors++;
                $display("FAIL reset_outputs: got v=%b r=%b s=%h c=%b want 0 0 0 0",
                         valid_o, ready_o, sum_o, carry_o);
            end
        end
        valid_i = 1'b0;
        rst_ni  = 1'b1;
        repeat (4) begin
            @(posedge clk_i);
            @(negedge clk_i);
            n_checks++;
            if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle: got ready=%b valid=%b want 1 0", ready_o, valid_o);
            end
        end
    endtask

    task automatic test_overflow();
        int lat; bit to;
        run_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, lat, to);
        n_checks++;
        if (to || lat != N) begin
            n_errors++;
            $display("FAIL ovf_latency: got %0d (timeout=%b) want %0d", lat, to, N);
        end
        n_checks++;
        if ({carry_o, sum_o} !== {1'b1, 32'h0}) begin
            n_errors++;
            $display("FAIL ovf_result: got c=%b s=%h want 1 00000000", carry_o, sum_o);
        end
        consume();
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_return_idle: got ready=%b valid=%b want 1 0", ready_o, valid_o);
        end
    endtask

    task automatic test_pattern();
        int lat; bit to;
        run_op(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, lat, to);
        n_checks++;
        if (to || {carry_o, sum_o} !== {1'b0, 32'h9999_9999}) begin
            n_errors++;
            $display("FAIL pattern_result: got c=%b s=%h (timeout=%b) want 0 99999999",
                     carry_o, sum_o, to);
        end
        consume();
    endtask

    task automatic test_hold();
        int lat; bit to;
        logic [W:0] exp;
        exp = ref_add(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b1);
        run_op(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b1, 1'b0, lat, to);
        for (int i = 0; i < 5; i++) begin
            a_i = $urandom; b_i = $urandom; carry_i = 1'b1; valid_i = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
            n_checks++;
            if (to || valid_o !== 1'b1 || ready_o !== 1'b0 || {carry_o, sum_o} !== exp) begin
                n_errors++;
                $display("FAIL hold_stable: got v=%b r=%b c=%b s=%h want 1 0 %b %h",
                         valid_o, ready_o, carry_o, sum_o, exp[W], exp[W-1:0]);
            end
        end
        valid_i = 1'b0;
        consume();
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_release: got ready=%b valid=%b want 1 0", ready_o, valid_o);
        end
        repeat (3) begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || {carry_o, sum_o} !== exp) begin
            n_errors++;
            $display("FAIL hold_no_accept: got r=%b v=%b c=%b s=%h want 1 0 %b %h",
                     ready_o, valid_o, carry_o, sum_o, exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_random();
        int lat; bit to;
        logic [W-1:0] a, b;
        logic c;
        logic [W:0] exp;
        int waits;
        run_op(32'h1, 32'h1, 1'b0, 1'b1, lat, to);
        n_checks++;
        if (to || {carry_o, sum_o} !== {1'b0, 32'h2}) begin
            n_errors++;
            $display("FAIL scramble_result: got c=%b s=%h want 0 00000002", carry_o, sum_o);
        end
        consume();
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom; c = 1'($urandom);
            if (i % 10 == 0) b = ~a;
            exp = ref_add(a, b, c);
            run_op(a, b, c, (i % 3 == 0), lat, to);
            waits = $urandom_range(0, 3);
            for (int k = 0; k < waits; k++) begin
                @(posedge clk_i);
                @(negedge clk_i);
            end
            n_checks++;
            if (to || valid_o !== 1'b1 || lat != N || {carry_o, sum_o} !== exp) begin
                n_errors++;
                $display("FAIL random_op %0d: a=%h b=%h ci=%b got c=%b s=%h lat=%0d want %b %h lat=%0d",
                         i, a, b, c, carry_o, sum_o, lat, exp[W], exp[W-1:0], N);
            end
            consume();
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat; bit to;
        bit seen;
        @(negedge clk_i);
        a_i = 32'h7777_7777; b_i = 32'h1111_1111; carry_i = 1'b1; valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (valid_o) seen = 1'b1;
        end
        n_checks++;
        if (seen || ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL midcalc_discard: got valid_seen=%b ready=%b want 0 1", seen, ready_o);
        end
        run_op(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, lat, to);
        n_checks++;
        if (to || {carry_o, sum_o} !== {1'b0, 32'h10}) begin
            n_errors++;
            $display("FAIL midcalc_next_op: got c=%b s=%h want 0 00000010", carry_o, sum_o);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_pattern();
        test_hold();
        test_random();
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
